// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the HI/LO path: one quotient bit per cycle,
// holds the pipeline stalled via busy_o and presents LO=quotient, HI=remainder.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             whilo_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sgn;
  logic             neg1;
  logic             neg2;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // A partial remainder that does not fit is below the divisor, so its top bit is 0.
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    fits     = (trial >= {1'b0, dvs});
    rem_next = fits ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

  assign busy_o = ((state == IDLE) && start_i && !annul_i) ||
                  ((state == RUN) && !annul_i) ||
                  ((state == BYZERO) && !annul_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      sgn     <= 1'b0;
      neg1    <= 1'b0;
      neg2    <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      ready_o <= 1'b0;
      whilo_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            sgn  <= signed_i;
            neg1 <= signed_i && opdata1_i[WIDTH-1];
            neg2 <= signed_i && opdata2_i[WIDTH-1];
            quo  <= (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
            dvs  <= (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
            rem  <= '0;
            cnt  <= '0;
            state <= (opdata2_i == '0) ? BYZERO : RUN;
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state   <= DONE;
            hi_o    <= '0;
            lo_o    <= '0;
            ready_o <= 1'b1;
            whilo_o <= 1'b1;
          end
        end
        RUN: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              // Sign fix is applied on the final iteration's results.
              state   <= DONE;
              ready_o <= 1'b1;
              whilo_o <= 1'b1;
              lo_o    <= (sgn && (neg1 ^ neg2)) ? -quo_next : quo_next;
              hi_o    <= (sgn && neg1) ? -rem_next : rem_next;
            end
          end
        end
        DONE: begin
          if (!start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
            whilo_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
